// File: rtl/key_filter.sv
`timescale 1ns / 1ps
// Debouncer for a mechanical key: synchronises the raw input, filters each
// transition for CNT_MAX+1 stable clocks and reports confirmed edges.
module key_filter #(
  parameter int unsigned CNT_MAX = 999_999
) (
  input  logic Clk,
  input  logic Rst_n,
  input  logic key_in,
  output logic key_flag,
  output logic key_state
);

  typedef enum logic [1:0] {
    IDLE,
    FILT_DN,
    DOWN,
    FILT_UP
  } state_e;

  localparam logic [19:0] CNT_LAST = 20'(CNT_MAX);

  logic        s1_q, s2_q, s2_dly_q;
  logic        nedge, pedge;
  state_e      state_q;
  logic [19:0] cnt_q;
  logic        key_flag_q, key_state_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, which is what makes the chain a
  // synchroniser rather than a single wire.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      s1_q     <= 1'b1;
      s2_q     <= 1'b1;
      s2_dly_q <= 1'b1;
    end else begin
      s1_q     <= key_in;
      s2_q     <= s1_q;
      s2_dly_q <= s2_q;
    end
  end

  assign nedge = s2_dly_q & ~s2_q;
  assign pedge = ~s2_dly_q & s2_q;

  // An opposite edge is tested before the terminal count, so a bounce that
  // lands on the last filter cycle still aborts the event.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      key_flag_q  <= 1'b0;
      key_state_q <= 1'b1;
    end else begin
      key_flag_q <= 1'b0;
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (nedge) state_q <= FILT_DN;
        end
        FILT_DN: begin
          if (pedge) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q     <= DOWN;
            cnt_q       <= '0;
            key_flag_q  <= 1'b1;
            key_state_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 20'd1;
          end
        end
        DOWN: begin
          cnt_q <= '0;
          if (pedge) state_q <= FILT_UP;
        end
        FILT_UP: begin
          if (nedge) begin
            state_q <= DOWN;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            key_flag_q  <= 1'b1;
            key_state_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 20'd1;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign key_flag  = key_flag_q;
  assign key_state = key_state_q;

endmodule

// File: tb/tb_key_filter.sv
`timescale 1ns / 1ps
// Directed bench for key_filter with CNT_MAX = 99: edge-exact flag timing,
// bounce rejection, boundary abort and asynchronous reset behaviour.
module tb_key_filter;

  logic Clk;
  logic Rst_n;
  logic key_in;
  logic key_flag;
  logic key_state;

  int vectors;
  int miscompares;

  key_filter #(.CNT_MAX(99)) dut (
    .Clk      (Clk),
    .Rst_n    (Rst_n),
    .key_in   (key_in),
    .key_flag (key_flag),
    .key_state(key_state)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  initial begin
    #900_000;
    $display("FAIL timeout: observed no end of stimulus, expected finish");
    $fatal(1, "simulation time limit reached");
  end

  task automatic check(input string tag, input int observed, input int expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Runs n rising edges, sampling 1 ns after each. Edge 1 is the first edge
  // after the call. Reports first flag edge, flag count and the edge on which
  // key_state first left its starting value (-1 when never seen).
  task automatic watch(input int n, output int first, output int nflags, output int ks_edge);
    logic ks0;
    ks0     = key_state;
    first   = -1;
    nflags  = 0;
    ks_edge = -1;
    for (int i = 1; i <= n; i++) begin
      @(posedge Clk);
      #1;
      if (key_flag === 1'b1) begin
        nflags++;
        if (first < 0) first = i;
      end
      if (ks_edge < 0 && key_state !== ks0) ks_edge = i;
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge Clk);
      #1;
    end
  endtask

  int first, nfl, ksedge, noise, total, gap;

  initial begin
    vectors     = 0;
    miscompares = 0;
    key_in      = 1'b1;
    Rst_n       = 1'b1;
    #1;
    Rst_n = 1'b0;
    #1;
    check("reset_flag", int'(key_flag), 0);
    check("reset_state", int'(key_state), 1);
    tick(2);
    Rst_n = 1'b1;
    tick(5);
    check("idle_flag", int'(key_flag), 0);

    // Clean press then clean release
    key_in = 1'b0;
    watch(200, first, nfl, ksedge);
    check("press_edge", first, 103);
    check("press_count", nfl, 1);
    check("press_state_edge", ksedge, 103);
    check("press_state", int'(key_state), 0);
    key_in = 1'b1;
    watch(200, first, nfl, ksedge);
    check("release_edge", first, 103);
    check("release_count", nfl, 1);
    check("release_state_edge", ksedge, 103);
    check("release_state", int'(key_state), 1);

    // 500 ns glitch
    key_in = 1'b0;
    watch(50, first, nfl, ksedge);
    total  = nfl;
    key_in = 1'b1;
    watch(200, first, nfl, ksedge);
    total += nfl;
    check("glitch_flags", total, 0);
    check("glitch_state", int'(key_state), 1);

    // Bouncy press: toggles with gaps under 99 clocks, then held low
    noise = 0;
    for (int i = 0; i < 50; i++) begin
      key_in = ~key_in;
      gap    = int'($urandom_range(1, 98));
      watch(gap, first, nfl, ksedge);
      noise += nfl;
    end
    check("bounce_press_noise", noise, 0);
    key_in = 1'b0;
    watch(200, first, nfl, ksedge);
    total = noise + nfl;
    check("bounce_press_edge", first, 103);
    check("bounce_press_count", nfl, 1);
    check("bounce_press_state", int'(key_state), 0);

    // Bouncy release
    noise = 0;
    for (int i = 0; i < 50; i++) begin
      key_in = ~key_in;
      gap    = int'($urandom_range(1, 98));
      watch(gap, first, nfl, ksedge);
      noise += nfl;
    end
    check("bounce_release_noise", noise, 0);
    key_in = 1'b1;
    watch(200, first, nfl, ksedge);
    total += noise + nfl;
    check("bounce_release_edge", first, 103);
    check("bounce_release_state", int'(key_state), 1);
    check("full_cycle_flags", total, 2);

    // Release lands exactly as cnt reaches 99: abort wins
    key_in = 1'b0;
    watch(100, first, nfl, ksedge);
    total  = nfl;
    key_in = 1'b1;
    watch(200, first, nfl, ksedge);
    total += nfl;
    check("abort_flags", total, 0);
    check("abort_state", int'(key_state), 1);

    // One clock longer: press confirms, then the release filters normally
    key_in = 1'b0;
    watch(101, first, nfl, ksedge);
    check("late_release_preflags", nfl, 0);
    key_in = 1'b1;
    watch(200, first, nfl, ksedge);
    check("late_release_first", first, 2);
    check("late_release_count", nfl, 2);
    check("late_release_state", int'(key_state), 1);

    // Asynchronous reset while pressed
    key_in = 1'b0;
    watch(110, first, nfl, ksedge);
    check("pre_reset_press", first, 103);
    check("pre_reset_state", int'(key_state), 0);
    #2;
    Rst_n = 1'b0;
    #1;
    check("async_reset_state", int'(key_state), 1);
    check("async_reset_flag", int'(key_flag), 0);
    tick(2);

    // Key low at reset release: new press; then reset at cnt = 50 discards it
    Rst_n = 1'b1;
    watch(53, first, nfl, ksedge);
    check("mid_filter_flags", nfl, 0);
    Rst_n = 1'b0;
    #1;
    check("mid_filter_reset_flag", int'(key_flag), 0);
    check("mid_filter_reset_state", int'(key_state), 1);
    watch(3, first, nfl, ksedge);
    check("in_reset_flags", nfl, 0);
    Rst_n = 1'b1;
    watch(200, first, nfl, ksedge);
    check("post_reset_press_edge", first, 103);
    check("post_reset_press_count", nfl, 1);
    check("post_reset_press_state", int'(key_state), 0);

    key_in = 1'b1;
    watch(200, first, nfl, ksedge);
    check("final_release_edge", first, 103);
    check("final_release_state", int'(key_state), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/key_filter.md
KEY_FILTER -- requirements
Module: key_filter

Interface
REQ-001 SHALL have parameter CNT_MAX, default 999_999, meaning the stable-level hold count in clocks minus one (20 ms at 50 MHz); legal range 1 to 2^20-1.
REQ-002 SHALL have port Clk, input, 1, system clock; all state changes on its rising edge.
REQ-003 SHALL have port Rst_n, input, 1, reset, asynchronous active-low.
REQ-004 SHALL have port key_in, input, 1, raw mechanical key, asynchronous to Clk, 1 = released, 0 = pressed, may bounce on both transitions.
REQ-005 SHALL have port key_flag, output, 1, single-cycle pulse marking one confirmed press or release.
REQ-006 SHALL have port key_state, output, 1, debounced level, 1 = released, 0 = pressed.

Function
REQ-007 SHALL pass key_in through a two-flop synchronizer (s1, s2), followed by one delay flop s2_d; all three reset to 1.
REQ-008 SHALL decode nedge = s2_d & ~s2 and pedge = ~s2_d & s2 combinationally.
REQ-009 SHALL implement a four-state FSM: IDLE (released, stable), FILT_DN (press filtering), DOWN (pressed, stable), FILT_UP (release filtering).
REQ-010 SHALL hold a 20-bit counter cnt that increments by 1 per clock only in FILT_DN/FILT_UP, and clears to 0 on every entry to a filter state and in IDLE/DOWN.
REQ-011 IDLE: on nedge go to FILT_DN; pedge ignored.
REQ-012 FILT_DN: on pedge return to IDLE with no flag (bounce abort); else on cnt == CNT_MAX go to DOWN; else stay.
REQ-013 DOWN: on pedge go to FILT_UP; nedge ignored.
REQ-014 FILT_UP: on nedge return to DOWN with no flag; else on cnt == CNT_MAX go to IDLE; else stay.
REQ-015 SHALL treat an abort edge arriving in the same cycle as cnt == CNT_MAX as an abort (edge wins, no flag).
REQ-016 SHALL register key_flag = 1 for exactly one clock on the FILT_DN->DOWN and FILT_UP->IDLE transitions, 0 otherwise.
REQ-017 SHALL register key_state: 0 on the FILT_DN->DOWN edge, 1 on the FILT_UP->IDLE edge, otherwise held; key_state changes only on the edge where key_flag rises.
REQ-018 Latency: with key_in stable from its first sampling edge (edge 1), key_flag and the new key_state SHALL be high/valid after rising edge CNT_MAX+4.
REQ-019 SHALL never emit two flags of the same direction consecutively; flags strictly alternate press, release.
REQ-020 cnt SHALL never exceed CNT_MAX (no wrap).

Reset
REQ-021 On Rst_n low, immediately and regardless of Clk: state = IDLE, cnt = 0, s1 = s2 = s2_d = 1, key_flag = 0, key_state = 1.
REQ-022 Reset mid-filter SHALL discard the pending event; no flag after reset release unless a new filter completes.
REQ-023 If key_in is low at reset release, it SHALL be treated as a new press: nedge, then a press flag after full filtering.

Verification (CNT_MAX = 99, Clk 10 ns)
REQ-024 Clean press: key_in 1->0 held 2 us -> one key_flag pulse on edge 103, key_state 1->0 on the same edge, no further flags.
REQ-025 Bouncy press: 50 random toggles with gaps < 990 ns, then held low -> exactly one press flag, 103 edges after the last toggle.
REQ-026 Short glitch: key_in low for 500 ns then high -> no flag, key_state stays 1, FSM back in IDLE.
REQ-027 Full cycle: bouncy press then bouncy release -> exactly two flags, key_state sequence 1, 0, 1.
REQ-028 Reset at cnt = 50 in FILT_DN with key_in still low -> outputs clear asynchronously; after release, one press flag at edge 103 after reset deasserts.
REQ-029 Abort at boundary: pedge coincident with cnt == 99 in FILT_DN -> no flag, state IDLE.
